encoder_pos_snapshot: RTL

- Upstream feeder for the SPI slave encoder interface.
- Decodes a quadrature encoder (A/B/Z) into a 32-bit position count.
- On each SPI frame start (cs_n falling), freezes position, compensated position and a parameter/status word, so the three 32-bit words stay stable while the slave shifts them out on scl.
- All logic is in the sys_clk domain; cs_n and encoder pins are asynchronous inputs.

---
 rtl/encoder_pkg.sv | 23 ++
 rtl/quad_decoder.sv | 16 +
 rtl/encoder_pos_snapshot.sv | 137 +++++++++++++
 3 files changed

// File: rtl/encoder_pkg.sv
// rtl/encoder_pkg.sv - shared constants for the encoder position snapshot block
package encoder_pkg;

  localparam int POS_W = 32;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_HOLD    = 2'd2;

  localparam int PARA_ERR_BIT = 15;
  localparam int PARA_IDX_BIT = 14;

  // Forward successor in the x4 Gray cycle 00 -> 01 -> 11 -> 10 -> 00
  function automatic logic [1:0] quad_next(input logic [1:0] ab);
    case (ab)
      2'b00:   quad_next = 2'b01;
      2'b01:   quad_next = 2'b11;
      2'b11:   quad_next = 2'b10;
      default: quad_next = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - x4 quadrature step decoder on synchronised {a,b}
module quad_decoder
  import encoder_pkg::*;
(
  input  logic [1:0] ab,
  input  logic [1:0] ab_prev,
  output logic       inc,
  output logic       dec,
  output logic       illegal
);

  assign inc     = (ab == quad_next(ab_prev));
  assign dec     = (ab_prev == quad_next(ab));
  assign illegal = ((ab ^ ab_prev) == 2'b11);

endmodule

// File: rtl/encoder_pos_snapshot.sv
// rtl/encoder_pos_snapshot.sv - quadrature position counter with cs_n-triggered snapshot
// Optional ENC_INDEX_CLEAR_EN: index rising edge clears the position count.
module encoder_pos_snapshot
  import encoder_pkg::*;
#(
  parameter int               SYNC_STAGES = 2,
  parameter logic [POS_W-1:0] POS_RESET   = '0
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             enc_z,
  input  logic             cs_n,
  input  logic [POS_W-1:0] cfg_offset,
  input  logic [15:0]      cfg_para,
  output logic [POS_W-1:0] dsp_data_para,
  output logic [POS_W-1:0] dsp_data_position,
  output logic [POS_W-1:0] dsp_data_position_compen,
  output logic             snap_valid,
  output logic             err_illegal
);

`ifdef ENC_INDEX_CLEAR_EN
  localparam bit IDX_CLEAR = 1'b1;
`else
  localparam bit IDX_CLEAR = 1'b0;
`endif

  logic [SYNC_STAGES-1:0] a_sync, b_sync, z_sync, cs_sync;
  logic [1:0]             ab_prev;
  logic                   z_prev, cs_prev;
  logic [POS_W-1:0]       pos_cnt;
  logic [7:0]             frame_cnt;
  logic                   err_sticky, idx_seen;
  logic [1:0]             state;
  logic [POS_W-1:0]       para_w;
  logic                   inc, dec, illegal;

  wire [1:0] ab_s    = {a_sync[SYNC_STAGES-1], b_sync[SYNC_STAGES-1]};
  wire       z_s     = z_sync[SYNC_STAGES-1];
  wire       cs_s    = cs_sync[SYNC_STAGES-1];
  wire       z_rise  = z_s & ~z_prev;
  wire       cs_fall = cs_prev & ~cs_s;
  wire       load    = (state == S_IDLE) && cs_fall;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      a_sync  <= '0;
      b_sync  <= '0;
      z_sync  <= '0;
      cs_sync <= '1;
      ab_prev <= 2'b00;
      z_prev  <= 1'b0;
      cs_prev <= 1'b1;
    end else begin
      a_sync  <= {a_sync[SYNC_STAGES-2:0], enc_a};
      b_sync  <= {b_sync[SYNC_STAGES-2:0], enc_b};
      z_sync  <= {z_sync[SYNC_STAGES-2:0], enc_z};
      cs_sync <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      ab_prev <= ab_s;
      z_prev  <= z_s;
      cs_prev <= cs_s;
    end
  end

  quad_decoder u_quad (
    .ab      (ab_s),
    .ab_prev (ab_prev),
    .inc     (inc),
    .dec     (dec),
    .illegal (illegal)
  );

  // A same-cycle set beats the read-to-clear of a capture
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      pos_cnt    <= POS_RESET;
      err_sticky <= 1'b0;
      idx_seen   <= 1'b0;
    end else begin
      if (IDX_CLEAR && z_rise) pos_cnt <= '0;
      else if (inc)            pos_cnt <= pos_cnt + 1'b1;
      else if (dec)            pos_cnt <= pos_cnt - 1'b1;
      err_sticky <= illegal | (err_sticky & ~load);
      idx_seen   <= z_rise  | (idx_seen & ~load);
    end
  end

  always_comb begin
    para_w               = '0;
    para_w[31:16]        = cfg_para;
    para_w[PARA_ERR_BIT] = err_sticky;
    para_w[PARA_IDX_BIT] = idx_seen;
    para_w[7:0]          = frame_cnt;
  end

  // Snapshot registers load on the edge that enters S_CAPTURE so the
  // cs_n pin-to-output delay is SYNC_STAGES+1 cycles.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state                    <= S_IDLE;
      dsp_data_para            <= '0;
      dsp_data_position        <= '0;
      dsp_data_position_compen <= '0;
      snap_valid               <= 1'b0;
      frame_cnt                <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cs_fall) begin
            state                    <= S_CAPTURE;
            dsp_data_position        <= pos_cnt;
            dsp_data_position_compen <= pos_cnt + cfg_offset;
            dsp_data_para            <= para_w;
            frame_cnt                <= frame_cnt + 8'd1;
            snap_valid               <= 1'b1;
          end
        end
        S_CAPTURE: state <= S_HOLD;
        S_HOLD: begin
          if (cs_s) begin
            state      <= S_IDLE;
            snap_valid <= 1'b0;
          end
        end
        default: begin
          state      <= S_IDLE;
          snap_valid <= 1'b0;
        end
      endcase
    end
  end

  assign err_illegal = err_sticky;

endmodule
